// File: rtl/ihex_rx_loader.sv
// Intel HEX receive loader: parses records from the UART RX byte stream, verifies checksums
// and commits buffered data-record bytes to RAM one byte per cycle.
module ihex_rx_loader #(
  parameter int ADDR_W  = 10,
  parameter int MAX_LEN = 16
) (
  input  logic              CLK_UART_i,
  input  logic              RST_UART_n_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              rx_valid_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              mem_we_o,
  output logic              busy_o,
  output logic              rec_ok_o,
  output logic              rec_err_o,
  output logic              eof_o,
  output logic [7:0]        err_cnt_o
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_ADDR_H, S_ADDR_L, S_TYPE, S_DATA, S_CSUM, S_COMMIT
  } state_t;

  state_t            state, state_nx;
  logic              nib_hi;
  logic [3:0]        hi_q;
  logic [7:0]        sum_q, len_q, type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        buf_q [MAX_LEN];
  logic [ADDR_W-1:0] last_addr_q;
  logic [7:0]        last_data_q;
  logic              ok_q, err_q;

  logic              is_colon, is_hex, in_rec, byte_done, commit_last;
  logic [3:0]        nib;
  logic [7:0]        byte_v, sum_nx;
  logic              reject, accept_ok, set_eof;

  always_comb begin
    is_hex = 1'b1;
    nib    = '0;
    if (rx_byte_i >= 8'h30 && rx_byte_i <= 8'h39)      nib = rx_byte_i[3:0];
    else if (rx_byte_i >= 8'h41 && rx_byte_i <= 8'h46) nib = rx_byte_i[3:0] + 4'd9;
    else if (rx_byte_i >= 8'h61 && rx_byte_i <= 8'h66) nib = rx_byte_i[3:0] + 4'd9;
    else                                               is_hex = 1'b0;
  end

  assign is_colon    = (rx_byte_i == 8'h3A);
  assign byte_v      = {hi_q, nib};
  assign sum_nx      = sum_q + byte_v;
  assign in_rec      = (state != S_IDLE) && (state != S_COMMIT);
  assign byte_done   = rx_valid_i && in_rec && is_hex && nib_hi;
  assign commit_last = (state == S_COMMIT) && (8'(idx_q) == len_q - 8'd1);

  always_comb begin
    state_nx  = state;
    reject    = 1'b0;
    accept_ok = 1'b0;
    set_eof   = 1'b0;
    case (state)
      S_IDLE:   if (rx_valid_i && is_colon) state_nx = S_LEN;
      S_COMMIT: if (commit_last) state_nx = S_IDLE;
      default: begin
        if (rx_valid_i) begin
          if (is_colon) begin
            reject   = 1'b1;
            state_nx = S_LEN;
          end else if (!is_hex) begin
            reject   = 1'b1;
            state_nx = S_IDLE;
          end else if (nib_hi) begin
            case (state)
              S_LEN: begin
                if (byte_v > 8'(MAX_LEN)) begin
                  reject   = 1'b1;
                  state_nx = S_IDLE;
                end else begin
                  state_nx = S_ADDR_H;
                end
              end
              S_ADDR_H: state_nx = S_ADDR_L;
              S_ADDR_L: state_nx = S_TYPE;
              S_TYPE:   state_nx = (len_q == 8'd0) ? S_CSUM : S_DATA;
              S_DATA:   if (8'(idx_q) == len_q - 8'd1) state_nx = S_CSUM;
              S_CSUM: begin
                if (sum_nx != 8'd0) begin
                  reject   = 1'b1;
                  state_nx = S_IDLE;
                end else if (type_q == 8'h00 && len_q != 8'd0) begin
                  state_nx = S_COMMIT;
                end else begin
                  accept_ok = 1'b1;
                  set_eof   = (type_q == 8'h01);
                  state_nx  = S_IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Outside COMMIT the RAM bus shows the last written address/data.
  assign mem_we_o   = (state == S_COMMIT);
  assign mem_addr_o = mem_we_o ? addr_q + ADDR_W'(idx_q) : last_addr_q;
  assign mem_data_o = mem_we_o ? buf_q[idx_q] : last_data_q;
  assign rec_ok_o   = ok_q | commit_last;
  assign rec_err_o  = err_q;
  assign busy_o     = (state != S_IDLE);

  always_ff @(posedge CLK_UART_i or negedge RST_UART_n_i) begin
    if (!RST_UART_n_i) state <= S_IDLE;
    else               state <= state_nx;
  end

  always_ff @(posedge CLK_UART_i) begin
    if (byte_done && state == S_DATA) buf_q[idx_q] <= byte_v;
  end

  always_ff @(posedge CLK_UART_i or negedge RST_UART_n_i) begin
    if (!RST_UART_n_i) begin
      nib_hi      <= 1'b0;
      hi_q        <= '0;
      sum_q       <= '0;
      len_q       <= '0;
      type_q      <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      eof_o       <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      ok_q  <= accept_ok;
      err_q <= reject;
      if (set_eof) eof_o <= 1'b1;
      if (reject && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      if (state == S_COMMIT) begin
        last_addr_q <= mem_addr_o;
        last_data_q <= mem_data_o;
        idx_q       <= idx_q + 1'b1;
      end
      if (rx_valid_i && is_colon && state != S_COMMIT) begin
        nib_hi <= 1'b0;
        sum_q  <= '0;
      end else if (rx_valid_i && in_rec && is_hex) begin
        if (!nib_hi) begin
          hi_q   <= nib;
          nib_hi <= 1'b1;
        end else begin
          nib_hi <= 1'b0;
          sum_q  <= sum_nx;
          case (state)
            S_LEN:    len_q  <= byte_v;
            // High byte lands with a zero low byte so the low byte can simply be OR-ed in.
            S_ADDR_H: addr_q <= ADDR_W'({byte_v, 8'h00});
            S_ADDR_L: addr_q <= addr_q | ADDR_W'(byte_v);
            S_TYPE: begin
              type_q <= byte_v;
              idx_q  <= '0;
            end
            S_DATA:   idx_q  <= idx_q + 1'b1;
            S_CSUM:   idx_q  <= '0;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ihex_rx_loader.sv
// Bench for ihex_rx_loader: directed HEX records plus random records, checked against a
// character-level record model that predicts RAM writes, pulse cycles and counters.
module tb_ihex_rx_loader;
  localparam int ADDR_W  = 10;
  localparam int MAX_LEN = 16;
  localparam int GAP     = 18;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_byte = '0;
  logic              rx_valid = 1'b0;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_data_o;
  logic              mem_we_o, busy_o, rec_ok_o, rec_err_o, eof_o;
  logic [7:0]        err_cnt_o;

  ihex_rx_loader #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .CLK_UART_i(clk), .RST_UART_n_i(rst_n), .rx_byte_i(rx_byte), .rx_valid_i(rx_valid),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o), .busy_o(busy_o),
    .rec_ok_o(rec_ok_o), .rec_err_o(rec_err_o), .eof_o(eof_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_in, m_half, m_eof;
  int m_hinib, m_errcnt;
  int m_bytes[$];
  int exp_wa[$], exp_wd[$], exp_wc[$], exp_ok[$], exp_err[$];
  int obs_wa[$], obs_wd[$], obs_wc[$], obs_ok[$], obs_err[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we_o) begin
        obs_wa.push_back(int'(mem_addr_o));
        obs_wd.push_back(int'(mem_data_o));
        obs_wc.push_back(cyc);
      end
      if (rec_ok_o)  obs_ok.push_back(cyc);
      if (rec_err_o) obs_err.push_back(cyc);
      if (rec_ok_o || rec_err_o) chk("ok_err_exclusive", {31'd0, rec_ok_o && rec_err_o}, 32'd0);
    end
  end

  function automatic bit hexval(input logic [7:0] c, output int v);
    v = 0;
    if (c >= "0" && c <= "9") begin v = int'(c) - 48; return 1'b1; end
    if (c >= "A" && c <= "F") begin v = int'(c) - 55; return 1'b1; end
    if (c >= "a" && c <= "f") begin v = int'(c) - 87; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_err(input int vcyc);
    exp_err.push_back(vcyc);
    if (m_errcnt < 255) m_errcnt++;
    m_in = 1'b0;
  endtask

  task automatic model_finish(input int vcyc);
    int sum = 0;
    int ll, a, tt;
    foreach (m_bytes[i]) sum += m_bytes[i];
    m_in = 1'b0;
    if (sum % 256 != 0) begin model_err(vcyc); return; end
    ll = m_bytes[0];
    a  = m_bytes[1] * 256 + m_bytes[2];
    tt = m_bytes[3];
    if (tt == 0 && ll > 0) begin
      for (int k = 0; k < ll; k++) begin
        exp_wa.push_back((a + k) % (1 << ADDR_W));
        exp_wd.push_back(m_bytes[4 + k]);
        exp_wc.push_back(vcyc + k);
      end
      exp_ok.push_back(vcyc + ll - 1);
    end else begin
      exp_ok.push_back(vcyc);
      if (tt == 1) m_eof = 1'b1;
    end
  endtask

  task automatic model_char(input logic [7:0] c, input int vcyc);
    int v;
    if (c == ":") begin
      if (m_in) model_err(vcyc);
      m_in = 1'b1;
      m_half = 1'b0;
      m_bytes.delete();
    end else if (m_in) begin
      if (!hexval(c, v)) model_err(vcyc);
      else if (!m_half) begin
        m_hinib = v;
        m_half = 1'b1;
      end else begin
        m_half = 1'b0;
        m_bytes.push_back(m_hinib * 16 + v);
        if (m_bytes.size() == 1 && m_bytes[0] > MAX_LEN) model_err(vcyc);
        else if (m_bytes.size() == m_bytes[0] + 5) model_finish(vcyc);
      end
    end
  endtask

  task automatic clear_queues();
    exp_wa.delete(); exp_wd.delete(); exp_wc.delete(); exp_ok.delete(); exp_err.delete();
    obs_wa.delete(); obs_wd.delete(); obs_wc.delete(); obs_ok.delete(); obs_err.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    model_char(b, cyc + 1);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":n_wr"}, obs_wa.size(), exp_wa.size());
    for (int i = 0; i < exp_wa.size() && i < obs_wa.size(); i++) begin
      chk({tag, ":wr_addr"}, obs_wa[i], exp_wa[i]);
      chk({tag, ":wr_data"}, obs_wd[i], exp_wd[i]);
      chk({tag, ":wr_cyc"}, obs_wc[i], exp_wc[i]);
    end
    chk({tag, ":n_ok"}, obs_ok.size(), exp_ok.size());
    for (int i = 0; i < exp_ok.size() && i < obs_ok.size(); i++)
      chk({tag, ":ok_cyc"}, obs_ok[i], exp_ok[i]);
    chk({tag, ":n_err"}, obs_err.size(), exp_err.size());
    for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++)
      chk({tag, ":err_cyc"}, obs_err[i], exp_err[i]);
    chk({tag, ":err_cnt"}, err_cnt_o, m_errcnt);
    chk({tag, ":eof"}, eof_o, m_eof);
    chk({tag, ":busy"}, busy_o, m_in);
    chk({tag, ":we_idle"}, mem_we_o, 0);
    if (exp_wa.size() > 0) begin
      chk({tag, ":addr_hold"}, mem_addr_o, exp_wa[exp_wa.size() - 1]);
      chk({tag, ":data_hold"}, mem_data_o, exp_wd[exp_wd.size() - 1]);
    end
    clear_queues();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ":addr"}, mem_addr_o, 0);
    chk({tag, ":data"}, mem_data_o, 0);
    chk({tag, ":we"}, mem_we_o, 0);
    chk({tag, ":busy"}, busy_o, 0);
    chk({tag, ":ok"}, rec_ok_o, 0);
    chk({tag, ":err"}, rec_err_o, 0);
    chk({tag, ":eof"}, eof_o, 0);
    chk({tag, ":err_cnt"}, err_cnt_o, 0);
  endtask

  function automatic logic [7:0] hexch(input int v, input bit lower);
    if (v < 10) return 8'(48 + v);
    return lower ? 8'(87 + v) : 8'(55 + v);
  endfunction

  task automatic send_random();
    int ll, a, tt, sum, r;
    int b[$];
    logic [7:0] ch[$];
    logic [7:0] junk[4];
    junk[0] = "G"; junk[1] = ":"; junk[2] = "z"; junk[3] = " ";
    ll = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(0, MAX_LEN));
    a  = int'($urandom_range(0, 65535));
    r  = int'($urandom_range(0, 9));
    tt = (r < 7) ? 0 : (r < 9) ? 1 : 4;
    b.push_back(ll); b.push_back(a / 256); b.push_back(a % 256); b.push_back(tt);
    for (int i = 0; i < ll; i++) b.push_back(int'($urandom_range(0, 255)));
    sum = 0;
    foreach (b[i]) sum += b[i];
    sum = (256 - sum % 256) % 256;
    if ($urandom_range(0, 7) == 0) sum = sum ^ (1 << $urandom_range(0, 7));
    b.push_back(sum);
    ch.push_back(":");
    foreach (b[i]) begin
      ch.push_back(hexch(b[i] / 16, 1'($urandom_range(0, 1))));
      ch.push_back(hexch(b[i] % 16, 1'($urandom_range(0, 1))));
    end
    if ($urandom_range(0, 7) == 0) ch[$urandom_range(1, ch.size() - 1)] = junk[$urandom_range(0, 3)];
    if ($urandom_range(0, 1) == 1) begin ch.push_back(8'h0D); ch.push_back(8'h0A); end
    foreach (ch[i]) send_byte(ch[i]);
  endtask

  initial begin
    m_in = 0; m_half = 0; m_eof = 0; m_hinib = 0; m_errcnt = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_str(":0300100012AB34FC");
    chk("t1_first_addr", obs_wa.size() > 0 ? obs_wa[0] : -1, 32'h010);
    chk("t1_last_data", obs_wd.size() > 2 ? obs_wd[2] : -1, 32'h34);
    check_all("t1");

    send_str(":00000001FF");
    send_byte(8'h0D);
    send_byte(8'h0A);
    chk("t2_eof_const", eof_o, 1);
    check_all("t2");

    send_str(":0300100012AB34FD");
    chk("t3_err_cnt_const", err_cnt_o, 1);
    check_all("t3");
    send_str(":0300100012AB34FC");
    check_all("t3_next");

    send_str(":11");
    chk("t4_err_after_len", obs_err.size() > 0 ? obs_err[0] : -1, exp_err.size() > 0 ? exp_err[0] : -2);
    send_str("0000000102");
    check_all("t4");

    send_str(":0203FF00a55afd");
    chk("t5_wrap_addr", obs_wa.size() > 1 ? obs_wa[1] : -1, 32'h000);
    check_all("t5");

    send_str(":030010");
    chk("t6_busy_mid", busy_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    m_in = 0; m_half = 0; m_eof = 0; m_errcnt = 0;
    @(negedge clk);
    clear_queues();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_str(":0300100012AB34FC");
    check_all("t6_after");

    for (int n = 0; n < 30; n++) begin
      send_random();
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
